// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline types: ID/EX control bundle, ID/EX register layout, opcodes.
// Pure declarations, no timing. Used by the ID/EX stage, EX stage and forwarding logic.
package pipe_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       br_un;
        logic       rd_wren;
        logic       mem_wren;
        logic [1:0] wb_sel;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [1:0] opa_sel;
        logic       opb_sel;
        logic       insn_vld;
        logic [3:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        id_ex_ctrl_t ctrl;
    } id_ex_reg_t;

    // A bubble must look like a harmless ALU NOP to everything downstream.
    function automatic id_ex_ctrl_t nop_ctrl();
        id_ex_ctrl_t c;
        c        = '0;
        c.alu_op = ALU_NOP;
        c.br_un  = 1'b1;
        return c;
    endfunction

    function automatic id_ex_reg_t bubble_reg();
        id_ex_reg_t r;
        r      = '0;
        r.ctrl = nop_ctrl();
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Purely combinational, zero latency; no backpressure of its own.
// Result feeds the stall/bubble decision in id_ex_stage.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic        id_vld,
    input  logic [31:0] instr,
    input  logic        ex_vld,
    input  logic [4:0]  ex_rd,
    input  id_ex_ctrl_t ex_ctrl,
    output logic        load_use
);

    logic [6:0] opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       ex_is_load;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign id_rs1 = instr[19:15];
    assign id_rs2 = instr[24:20];

    // LUI/AUIPC/JAL carry immediate bits in the rs fields, so they must not match.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ITYPE, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    assign ex_is_load = ex_vld & ex_ctrl.rd_wren & (ex_ctrl.wb_sel == WB_MEM) & (ex_rd != 5'd0);
    assign rs1_hit    = use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = use_rs2 & (id_rs2 == ex_rd);
    assign load_use   = ex_is_load & id_vld & (rs1_hit | rs2_hit);

    assign unused_bits = ^{instr[31:25], instr[14:7], ex_ctrl.br_un, ex_ctrl.mem_wren,
                           ex_ctrl.is_branch, ex_ctrl.is_jal, ex_ctrl.is_jalr,
                           ex_ctrl.opa_sel, ex_ctrl.opb_sel, ex_ctrl.insn_vld, ex_ctrl.alu_op};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and redirect flush.
// Latency 1 cycle ID->EX; o_stall_id/o_flush_id are combinational (0 cycles).
// i_ex_stall freezes the whole register; redirect and load-use replace the capture with a bubble.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_vld,
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_rs1_data,
    input  logic [31:0]      i_rs2_data,
    input  logic [31:0]      i_imm,
    input  id_ex_ctrl_t      i_ctrl,
    input  logic             i_ex_stall,
    input  logic             i_redirect,
    output logic             o_ex_vld,
    output logic [31:0]      o_ex_pc,
    output logic [31:0]      o_ex_rs1_data,
    output logic [31:0]      o_ex_rs2_data,
    output logic [31:0]      o_ex_imm,
    output logic [4:0]       o_ex_rd,
    output logic [4:0]       o_ex_rs1,
    output logic [4:0]       o_ex_rs2,
    output logic [2:0]       o_ex_funct3,
    output id_ex_ctrl_t      o_ex_ctrl,
    output logic             o_stall_id,
    output logic             o_flush_id,
    output logic [CNT_W-1:0] o_bubble_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    id_ex_reg_t       ex_q;
    id_ex_reg_t       id_cap;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             load_use;

    load_use_detect u_load_use_detect (
        .id_vld   (i_id_vld),
        .instr    (i_instr),
        .ex_vld   (ex_q.vld),
        .ex_rd    (ex_q.rd),
        .ex_ctrl  (ex_q.ctrl),
        .load_use (load_use)
    );

    // An all-zero word is not a legal instruction; treat it as a bubble rather than decode it.
    always_comb begin
        id_cap = bubble_reg();
        if (i_instr != 32'd0) begin
            id_cap.vld      = i_id_vld & i_ctrl.insn_vld;
            id_cap.pc       = i_pc;
            id_cap.rs1_data = i_rs1_data;
            id_cap.rs2_data = i_rs2_data;
            id_cap.imm      = i_imm;
            id_cap.rd       = i_instr[11:7];
            id_cap.rs1      = i_instr[19:15];
            id_cap.rs2      = i_instr[24:20];
            id_cap.funct3   = i_instr[14:12];
            id_cap.ctrl     = i_ctrl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q         <= bubble_reg();
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (i_ex_stall) begin
            ex_q <= ex_q;
        end else if (i_redirect) begin
            ex_q <= bubble_reg();
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end else if (load_use) begin
            ex_q <= bubble_reg();
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end else begin
            ex_q <= id_cap;
        end
    end

    // A redirect kills the dependent instruction anyway, so it must not also hold the PC.
    assign o_stall_id = ~i_reset & (i_ex_stall | (load_use & ~i_redirect));
    assign o_flush_id = ~i_reset & ~i_ex_stall & i_redirect;

    assign o_ex_vld      = ex_q.vld;
    assign o_ex_pc       = ex_q.pc;
    assign o_ex_rs1_data = ex_q.rs1_data;
    assign o_ex_rs2_data = ex_q.rs2_data;
    assign o_ex_imm      = ex_q.imm;
    assign o_ex_rd       = ex_q.rd;
    assign o_ex_rs1      = ex_q.rs1;
    assign o_ex_rs2      = ex_q.rs2;
    assign o_ex_funct3   = ex_q.funct3;
    assign o_ex_ctrl     = ex_q.ctrl;
    assign o_bubble_cnt  = bubble_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected ID/EX contents are queued as stimulus is driven
// and popped one per clock edge for comparison.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [15:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             id_vld;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      imm;
    id_ex_ctrl_t      ctrl;
    logic             ex_stall;
    logic             redirect;
    logic             ex_vld;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_rs1_data;
    logic [31:0]      ex_rs2_data;
    logic [31:0]      ex_imm;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [2:0]       ex_funct3;
    id_ex_ctrl_t      ex_ctrl;
    logic             stall_id;
    logic             flush_id;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_id_vld      (id_vld),
        .i_instr       (instr),
        .i_pc          (pc),
        .i_rs1_data    (rs1_data),
        .i_rs2_data    (rs2_data),
        .i_imm         (imm),
        .i_ctrl        (ctrl),
        .i_ex_stall    (ex_stall),
        .i_redirect    (redirect),
        .o_ex_vld      (ex_vld),
        .o_ex_pc       (ex_pc),
        .o_ex_rs1_data (ex_rs1_data),
        .o_ex_rs2_data (ex_rs2_data),
        .o_ex_imm      (ex_imm),
        .o_ex_rd       (ex_rd),
        .o_ex_rs1      (ex_rs1),
        .o_ex_rs2      (ex_rs2),
        .o_ex_funct3   (ex_funct3),
        .o_ex_ctrl     (ex_ctrl),
        .o_stall_id    (stall_id),
        .o_flush_id    (flush_id),
        .o_bubble_cnt  (bubble_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    // Stall and redirect together is illegal; the stimulus never drives it.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            assert (!(ex_stall === 1'b1 && redirect === 1'b1))
            else begin
                n_fail++;
                $error("FAIL protocol: i_ex_stall and i_redirect both high");
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mk_ctrl(input logic wren, input logic mwren, input logic [1:0] wb,
                                            input logic opb, input logic [3:0] alu);
        // {br_un, rd_wren, mem_wren, wb_sel, is_branch, is_jal, is_jalr, opa_sel, opb_sel, insn_vld, alu_op}
        return {1'b0, wren, mwren, wb, 1'b0, 1'b0, 1'b0, 2'b00, opb, 1'b1, alu};
    endfunction

    function automatic exp_t bubble_exp();
        exp_t e;
        e.vld = 1'b0; e.pc = '0; e.rs1_data = '0; e.rs2_data = '0; e.imm = '0;
        e.rd = '0; e.rs1 = '0; e.rs2 = '0; e.funct3 = '0;
        e.ctrl = 16'h800F;
        return e;
    endfunction

    function automatic exp_t model_cap();
        exp_t e;
        if (instr == 32'd0) return bubble_exp();
        e.vld      = id_vld & ctrl.insn_vld;
        e.pc       = pc;
        e.rs1_data = rs1_data;
        e.rs2_data = rs2_data;
        e.imm      = imm;
        e.rd       = instr[11:7];
        e.rs1      = instr[19:15];
        e.rs2      = instr[24:20];
        e.funct3   = instr[14:12];
        e.ctrl     = ctrl;
        return e;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] rd);
        return {7'b0, r2, r1, 3'b000, rd, OP_RTYPE};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [15:0] c, input logic [31:0] p,
                         input logic [31:0] im);
        id_vld   = v;
        instr    = ins;
        ctrl     = c;
        pc       = p;
        imm      = im;
        rs1_data = p ^ 32'hA5A5_0000;
        rs2_data = p ^ 32'h0000_5A5A;
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            chk("ex_vld", ex_vld, e.vld);
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_rs1_data", ex_rs1_data, e.rs1_data);
            chk("ex_rs2_data", ex_rs2_data, e.rs2_data);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_rd", ex_rd, e.rd);
            chk("ex_rs1", ex_rs1, e.rs1);
            chk("ex_rs2", ex_rs2, e.rs2);
            chk("ex_funct3", ex_funct3, e.funct3);
            chk("ex_ctrl", ex_ctrl, e.ctrl);
        end
    endtask

    task automatic comb(input string tag, input logic exp_stall, input logic exp_flush);
        #1;
        chk({tag, "_stall"}, stall_id, exp_stall);
        chk({tag, "_flush"}, flush_id, exp_flush);
    endtask

    task automatic do_reset();
        reset = 1'b1; ex_stall = 1'b0; redirect = 1'b0;
        sb_q.push_back(bubble_exp());
        cyc();
        reset = 1'b0;
    endtask

    logic [31:0] ADDI_X1, LW_X5, LW_X0, ADD_X6_X5, ADD_X6_X0, ADD_X6_X1, LUI_X5, LUI_X7, SW_X5, ADDI_X3;
    logic [15:0] C_ADDI, C_LW, C_ADD, C_SW, C_LUI;

    initial begin
        ADDI_X1   = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_ITYPE);
        ADDI_X3   = enc_i(12'd9, 5'd1, 3'b000, 5'd3, OP_ITYPE);
        LW_X5     = enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LOAD);
        LW_X0     = enc_i(12'd0, 5'd2, 3'b010, 5'd0, OP_LOAD);
        ADD_X6_X5 = enc_r(5'd7, 5'd5, 5'd6);
        ADD_X6_X0 = enc_r(5'd0, 5'd0, 5'd6);
        ADD_X6_X1 = enc_r(5'd7, 5'd1, 5'd6);
        LUI_X5    = {20'h12345, 5'd5, OP_LUI};
        LUI_X7    = {20'h00028, 5'd7, OP_LUI};        // rs1 field reads 5
        SW_X5     = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, OP_STORE};
        C_ADDI    = mk_ctrl(1'b1, 1'b0, WB_ALU, 1'b1, 4'h0);
        C_LW      = mk_ctrl(1'b1, 1'b0, WB_MEM, 1'b1, 4'h0);
        C_ADD     = mk_ctrl(1'b1, 1'b0, WB_ALU, 1'b0, 4'h0);
        C_SW      = mk_ctrl(1'b0, 1'b1, WB_ALU, 1'b1, 4'h0);
        C_LUI     = mk_ctrl(1'b1, 1'b0, WB_ALU, 1'b1, 4'hA);

        // Reset held 3 cycles with addi in ID
        reset = 1'b1; ex_stall = 1'b0; redirect = 1'b0;
        drive(1'b1, ADDI_X1, C_ADDI, 32'h100, 32'd5);
        for (int i = 0; i < 3; i++) begin
            comb("rst", 1'b0, 1'b0);
            sb_q.push_back(bubble_exp());
            cyc();
            chk("rst_bubble_cnt", bubble_cnt, 0);
            chk("rst_flush_cnt", flush_cnt, 0);
        end
        reset = 1'b0;
        sb_q.push_back(model_cap());
        cyc();
        chk("first_rd", ex_rd, 1);
        chk("first_imm", ex_imm, 5);

        // ALU producer in EX is never a load-use source
        drive(1'b1, ADD_X6_X1, C_ADD, 32'h104, 32'd0);
        comb("alu_dep", 1'b0, 1'b0);
        sb_q.push_back(model_cap());
        cyc();

        // lw x5 ; add x6,x5,x7
        drive(1'b1, LW_X5, C_LW, 32'h108, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, ADD_X6_X5, C_ADD, 32'h10C, 32'd0);
        comb("lu_add", 1'b1, 1'b0);
        sb_q.push_back(bubble_exp());
        cyc();
        chk("lu_bubble_cnt", bubble_cnt, 1);
        comb("lu_cleared", 1'b0, 1'b0);
        sb_q.push_back(model_cap());
        cyc();
        chk("lu_add_rd", ex_rd, 6);

        // lw x0 ; add x6,x0,x0
        drive(1'b1, LW_X0, C_LW, 32'h110, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, ADD_X6_X0, C_ADD, 32'h114, 32'd0);
        comb("lw_x0", 1'b0, 1'b0);
        sb_q.push_back(model_cap());
        cyc();

        // lw x5 ; lui x5 / lui x7 with rs1 field == 5
        drive(1'b1, LW_X5, C_LW, 32'h118, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, LUI_X5, C_LUI, 32'h11C, 32'h1234_5000);
        comb("lui_x5", 1'b0, 1'b0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, LW_X5, C_LW, 32'h120, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, LUI_X7, C_LUI, 32'h124, 32'h0002_8000);
        comb("lui_x7", 1'b0, 1'b0);
        sb_q.push_back(model_cap());
        cyc();

        // lw x5 ; sw x5,0(x2) hazards through rs2
        drive(1'b1, LW_X5, C_LW, 32'h128, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, SW_X5, C_SW, 32'h12C, 32'd0);
        comb("lu_sw", 1'b1, 1'b0);
        sb_q.push_back(bubble_exp());
        cyc();
        chk("sw_bubble_cnt", bubble_cnt, 2);
        sb_q.push_back(model_cap());
        cyc();

        // All-zero instruction and an invalid slot
        drive(1'b1, 32'd0, C_ADDI, 32'h130, 32'd7);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b0, ADDI_X3, C_ADDI, 32'h134, 32'd9);
        sb_q.push_back(model_cap());
        cyc();

        // Redirect beats load-use
        do_reset();
        drive(1'b1, LW_X5, C_LW, 32'h200, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, ADD_X6_X5, C_ADD, 32'h204, 32'd0);
        redirect = 1'b1;
        comb("redir", 1'b0, 1'b1);
        sb_q.push_back(bubble_exp());
        cyc();
        redirect = 1'b0;
        chk("redir_flush_cnt", flush_cnt, 1);
        chk("redir_bubble_cnt", bubble_cnt, 0);

        // EX stall freezes a valid add for 3 cycles
        do_reset();
        drive(1'b1, ADD_X6_X1, C_ADD, 32'h300, 32'd0);
        sb_q.push_back(model_cap());
        cyc();
        drive(1'b1, ADDI_X3, C_ADDI, 32'h304, 32'd9);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            comb("exstall", 1'b1, 1'b0);
            sb_q.push_back(last_exp);
            cyc();
            chk("exstall_bubble_cnt", bubble_cnt, 0);
            chk("exstall_flush_cnt", flush_cnt, 0);
        end
        // Reset mid-stall, then mid-flush
        reset = 1'b1;
        comb("rst_stall", 1'b0, 1'b0);
        sb_q.push_back(bubble_exp());
        cyc();
        reset = 1'b0; ex_stall = 1'b0;
        sb_q.push_back(model_cap());
        cyc();
        reset = 1'b1; redirect = 1'b1;
        comb("rst_flush", 1'b0, 1'b0);
        sb_q.push_back(bubble_exp());
        cyc();
        reset = 1'b0; redirect = 1'b0;
        chk("rst_flush_cnt", flush_cnt, 0);

        // Bubble counter saturation at 15
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, LW_X5, C_LW, 32'h400 + 32'(i * 8), 32'd0);
            sb_q.push_back(model_cap());
            cyc();
            drive(1'b1, ADD_X6_X5, C_ADD, 32'h404 + 32'(i * 8), 32'd0);
            comb("sat", 1'b1, 1'b0);
            sb_q.push_back(bubble_exp());
            cyc();
            chk("sat_bubble_cnt", bubble_cnt, (i + 1 > 15) ? 15 : i + 1);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RV32I pipeline. It registers the decoded control bundle, operands and instruction fields produced in ID into the ID/EX register. It detects load-use hazards against the instruction currently in EX and inserts bubbles on load-use, EX stall and branch/jump redirect. It drives the hold/kill controls for PC and IF/ID, and keeps saturating counters of inserted bubbles and flushes.

## Interface
- CNT_W, 16, width of the saturating performance counters.
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_id_vld  in  1  IF/ID register holds a fetched instruction.
- i_instr  in  32  instruction in ID.
- i_pc  in  32  PC of instruction in ID.
- i_rs1_data, i_rs2_data  in  32 each  register-file read data.
- i_imm  in  32  sign-extended immediate.
- i_ctrl  in  id_ex_ctrl_t  decoded control bundle: br_un, rd_wren, mem_wren, wb_sel[1:0], is_branch, is_jal, is_jalr, opa_sel[1:0], opb_sel, insn_vld, alu_op[3:0].
- i_ex_stall  in  1  EX/MEM cannot accept; hold ID/EX.
- i_redirect  in  1  branch taken or jump resolved in EX this cycle.
- o_ex_vld  out  1  ID/EX holds a real instruction.
- o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm  out  32 each  registered copies.
- o_ex_rd, o_ex_rs1, o_ex_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- o_ex_funct3  out  3  instr[14:12].
- o_ex_ctrl  out  id_ex_ctrl_t  registered control bundle.
- o_stall_id  out  1  hold PC and IF/ID this cycle.
- o_flush_id  out  1  kill IF/ID contents this cycle.
- o_bubble_cnt, o_flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- Bubble value: o_ex_vld=0; all data, address and field outputs 0; o_ex_ctrl all-zero except alu_op=4'b1111 (NOP) and br_un=1. rd_wren, mem_wren, is_branch, is_jal and is_jalr are therefore 0.
- Reset value of every output: the bubble value. o_stall_id=0, o_flush_id=0, both counters 0.
- Source use, decoded from i_instr[6:0]:
  - use_rs1 for R, I, load, store, branch and JALR.
  - use_rs2 for R, store and branch.
  - LUI, AUIPC and JAL use neither source.
- load_use = o_ex_vld & o_ex_ctrl.rd_wren & (o_ex_ctrl.wb_sel==2'b01) & (o_ex_rd!=0) & i_id_vld & ((use_rs1 & i_instr[19:15]==o_ex_rd) | (use_rs2 & i_instr[24:20]==o_ex_rd)).
- Next-state priority, evaluated per edge:
  1. i_reset: load bubble, clear counters.
  2. i_ex_stall: hold all registers. Counters unchanged.
  3. i_redirect: load bubble. flush_cnt+1.
  4. load_use: load bubble. bubble_cnt+1.
  5. Otherwise capture ID. o_ex_vld = i_id_vld & i_ctrl.insn_vld. An all-zero instruction is captured as a bubble.
- i_redirect together with i_ex_stall is a protocol violation. Stall wins and the redirect is ignored; the bench flags it with an assertion.
- o_stall_id = ~i_reset & (i_ex_stall | (load_use & ~i_redirect)).
- o_flush_id = ~i_reset & ~i_ex_stall & i_redirect.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Capture latency is 1 cycle: ID values appear on o_ex_* after the next rising edge.
- o_stall_id and o_flush_id are combinational from current ID/EX state and inputs, with zero latency, so PC and IF/ID react at the same edge.
- A load-use stall lasts exactly 1 cycle. After the bubble, o_ex_vld=0, the hazard clears and the held instruction is captured on the following edge.
- Reset mid-stall or mid-flush: the next edge yields the bubble value. Stall and flush outputs are 0 while i_reset=1.

## Structure
- Shared package pipe_pkg holds the following, shared with the EX stage and hazard forwarding:
  - id_ex_ctrl_t packed struct.
  - Opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - ALU_NOP=4'b1111 and WB_ALU/WB_MEM/WB_PC4.
- One combinational sub-module, load_use_detect, takes the ID instruction plus EX rd/valid/ctrl and produces load_use. Registers and counters stay in id_ex_stage.

## Test plan
- Reset: i_reset=1 for 3 cycles with addi x1,x0,5 in ID -> o_ex_vld=0, o_ex_ctrl.alu_op=4'hF, counters 0. The first edge after release gives o_ex_vld=1, o_ex_rd=1, o_ex_imm=5.
- Load-use: EX holds lw x5, ID holds add x6,x5,x7 -> o_stall_id=1 in that cycle. The next edge inserts a bubble and bubble_cnt=1; the following edge captures add with o_ex_rd=6.
- No false hazard: lw x0 then add x6,x0,x0 -> no stall. lw x5 then lui x5,0x12345 -> no stall. lw x5 then sw x5,0(x2) -> stall, since rs2 is used.
- Redirect beats load-use: load_use and i_redirect both 1 -> o_flush_id=1, o_stall_id=0, bubble inserted, flush_cnt=1, bubble_cnt=0.
- EX stall: i_ex_stall=1 for 3 cycles while a valid add is in EX -> all o_ex_* frozen, o_stall_id=1, counters unchanged.
- Saturation: CNT_W=4 with 20 load-use events -> o_bubble_cnt reaches 15 and stays 15.
